// File: rtl/ide_host_pio_pkg.sv
// Shared constants, FSM encoding and task-file helpers for the IDE host PIO initiator.
package ide_host_pio_pkg;

    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_SECCNT  = 3'd2;
    localparam logic [2:0] REG_LBA0    = 3'd3;
    localparam logic [2:0] REG_LBA1    = 3'd4;
    localparam logic [2:0] REG_LBA2    = 3'd5;
    localparam logic [2:0] REG_DEVHEAD = 3'd6;
    localparam logic [2:0] REG_CMD     = 3'd7;

    localparam logic [7:0] CMD_IDENTIFY = 8'hEC;
    localparam logic [7:0] CMD_READ     = 8'h20;
    localparam logic [7:0] CMD_READ_DMA = 8'hC8;

    localparam logic [7:0] DEVHEAD_LBA  = 8'hE0;
    localparam logic [2:0] LAST_REG_IDX = 3'd5;

    typedef enum logic [3:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_RECOVER,
        WAIT_INT,
        RD_SETUP,
        RD_PULSE,
        RD_RECOVER,
        DONE
    } state_t;

    function automatic logic [2:0] tf_addr(input logic [2:0] idx);
        case (idx)
            3'd0:    tf_addr = REG_SECCNT;
            3'd1:    tf_addr = REG_LBA0;
            3'd2:    tf_addr = REG_LBA1;
            3'd3:    tf_addr = REG_LBA2;
            3'd4:    tf_addr = REG_DEVHEAD;
            default: tf_addr = REG_CMD;
        endcase
    endfunction

    // Task-file registers are byte wide; the upper half of the bus stays zero.
    function automatic logic [15:0] tf_data(input logic [2:0] idx, input logic [7:0] code,
                                            input logic [27:0] lba);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h01;
            3'd1:    b = lba[7:0];
            3'd2:    b = lba[15:8];
            3'd3:    b = lba[23:16];
            3'd4:    b = DEVHEAD_LBA | {4'h0, lba[27:24]};
            default: b = code;
        endcase
        tf_data = {8'h00, b};
    endfunction

endpackage

// File: rtl/ide_host_pio_if.sv
// Command-side and IDE control-pin bundle; master is the PIO initiator, slave the environment.
interface ide_host_pio_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_code;
    logic [27:0] cmd_lba;
    logic        cs0_n;
    logic [2:0]  addr;
    logic        diow_n;
    logic        dior_n;
    logic        intrq;
    logic [15:0] rd_word;
    logic        rd_valid;
    logic        done;
    logic        error;

    modport master (
        input  cmd_valid, cmd_code, cmd_lba, intrq,
        output cmd_ready, cs0_n, addr, diow_n, dior_n, rd_word, rd_valid, done, error
    );

    modport slave (
        output cmd_valid, cmd_code, cmd_lba, intrq,
        input  cmd_ready, cs0_n, addr, diow_n, dior_n, rd_word, rd_valid, done, error
    );
endinterface

// File: rtl/ide_host_pio_intrq_sync.sv
// Two-flop synchronizer for the device interrupt plus a sticky rising-edge flag.
// i_arm clears the flag but an edge seen in the arming cycle still sets it.
module ide_host_pio_intrq_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_intrq,
    input  logic i_arm,
    output logic o_edge_seen
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;
    logic r_seen;
    logic w_rise;

    assign w_rise      = r_sync & ~r_sync_d;
    assign o_edge_seen = r_seen;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
            r_seen   <= 1'b0;
        end else begin
            r_meta   <= i_intrq;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_seen   <= i_arm ? w_rise : (r_seen | w_rise);
        end
    end

endmodule

// File: rtl/ide_host_pio.sv
// Host PIO initiator: six timed task-file writes, wait for intrq, then WORDS timed data reads.
// One command in flight; cmd_ready only in IDLE, each read word pulses rd_valid the cycle after capture.
module ide_host_pio
    import ide_host_pio_pkg::*;
#(
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_PULSE     = 4,
    parameter int unsigned T_RECOVER   = 2,
    parameter int unsigned WORDS       = 256,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic           clk,
    input  logic           reset_n,
    ide_host_pio_if.master bus,
    inout  wire [15:0]     data_bus
);

    localparam int TW = 8;
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [TW-1:0] LD_SETUP   = TW'(T_SETUP - 1);
    localparam logic [TW-1:0] LD_PULSE   = TW'(T_PULSE - 1);
    localparam logic [TW-1:0] LD_RECOVER = TW'(T_RECOVER - 1);
    localparam logic [8:0]    LAST_WORD  = 9'(WORDS - 1);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(TIMEOUT_CYC);

    state_t        r_state;
    logic [TW-1:0] r_tcnt;
    logic [WW-1:0] r_wait_cnt;
    logic [2:0]    r_reg_idx;
    logic [8:0]    r_word_cnt;
    logic [7:0]    r_code;
    logic [27:0]   r_lba;
    logic          r_cmd_ready;
    logic          r_cs0_n;
    logic [2:0]    r_addr;
    logic          r_diow_n;
    logic          r_dior_n;
    logic          r_drv;
    logic [15:0]   r_wdat;
    logic [15:0]   r_rd_word;
    logic          r_rd_valid;
    logic          r_done;
    logic          r_error;
    logic          r_arm;
    logic          w_edge;

    ide_host_pio_intrq_sync u_intrq_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_intrq     (bus.intrq),
        .i_arm       (r_arm),
        .o_edge_seen (w_edge)
    );

    assign data_bus      = r_drv ? r_wdat : 16'hzzzz;
    assign bus.cmd_ready = r_cmd_ready;
    assign bus.cs0_n     = r_cs0_n;
    assign bus.addr      = r_addr;
    assign bus.diow_n    = r_diow_n;
    assign bus.dior_n    = r_dior_n;
    assign bus.rd_word   = r_rd_word;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.done      = r_done;
    assign bus.error     = r_error;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_tcnt      <= '0;
            r_wait_cnt  <= '0;
            r_reg_idx   <= '0;
            r_word_cnt  <= '0;
            r_code      <= '0;
            r_lba       <= '0;
            r_cmd_ready <= 1'b1;
            r_cs0_n     <= 1'b1;
            r_addr      <= REG_DATA;
            r_diow_n    <= 1'b1;
            r_dior_n    <= 1'b1;
            r_drv       <= 1'b0;
            r_wdat      <= '0;
            r_rd_word   <= '0;
            r_rd_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_arm       <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_arm      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_code      <= bus.cmd_code;
                        r_lba       <= bus.cmd_lba;
                        r_reg_idx   <= 3'd0;
                        r_addr      <= tf_addr(3'd0);
                        r_wdat      <= tf_data(3'd0, bus.cmd_code, bus.cmd_lba);
                        r_drv       <= 1'b1;
                        r_cs0_n     <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_tcnt      <= LD_SETUP;
                        r_state     <= WR_SETUP;
                    end
                end
                WR_SETUP: begin
                    if (r_tcnt == '0) begin
                        r_diow_n <= 1'b0;
                        r_tcnt   <= LD_PULSE;
                        r_state  <= WR_PULSE;
                    end else begin
                        r_tcnt <= r_tcnt - 1'b1;
                    end
                end
                WR_PULSE: begin
                    if (r_tcnt == '0) begin
                        r_diow_n <= 1'b1;
                        r_tcnt   <= LD_RECOVER;
                        r_state  <= WR_RECOVER;
                    end else begin
                        r_tcnt <= r_tcnt - 1'b1;
                    end
                end
                WR_RECOVER: begin
                    if (r_tcnt != '0) begin
                        r_tcnt <= r_tcnt - 1'b1;
                    end else if (r_reg_idx == LAST_REG_IDX) begin
                        r_drv      <= 1'b0;
                        r_cs0_n    <= 1'b1;
                        r_addr     <= REG_DATA;
                        r_wait_cnt <= WW'(1);
                        r_state    <= WAIT_INT;
                    end else begin
                        r_reg_idx <= r_reg_idx + 1'b1;
                        r_addr    <= tf_addr(r_reg_idx + 1'b1);
                        r_wdat    <= tf_data(r_reg_idx + 1'b1, r_code, r_lba);
                        // Arm the edge latch as the command write begins, so a fast device is not missed.
                        r_arm     <= (r_reg_idx + 1'b1 == LAST_REG_IDX);
                        r_tcnt    <= LD_SETUP;
                        r_state   <= WR_SETUP;
                    end
                end
                WAIT_INT: begin
                    if (w_edge) begin
                        r_cs0_n    <= 1'b0;
                        r_addr     <= REG_DATA;
                        r_word_cnt <= '0;
                        r_tcnt     <= LD_SETUP;
                        r_state    <= RD_SETUP;
                    end else if (r_wait_cnt == WAIT_MAX) begin
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                RD_SETUP: begin
                    if (r_tcnt == '0) begin
                        r_dior_n <= 1'b0;
                        r_tcnt   <= LD_PULSE;
                        r_state  <= RD_PULSE;
                    end else begin
                        r_tcnt <= r_tcnt - 1'b1;
                    end
                end
                RD_PULSE: begin
                    if (r_tcnt == '0) begin
                        r_rd_word  <= data_bus;
                        r_rd_valid <= 1'b1;
                        r_dior_n   <= 1'b1;
                        r_tcnt     <= LD_RECOVER;
                        r_state    <= RD_RECOVER;
                    end else begin
                        r_tcnt <= r_tcnt - 1'b1;
                    end
                end
                RD_RECOVER: begin
                    if (r_tcnt != '0) begin
                        r_tcnt <= r_tcnt - 1'b1;
                    end else if (r_word_cnt == LAST_WORD) begin
                        r_cs0_n <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        r_tcnt     <= LD_SETUP;
                        r_state    <= RD_SETUP;
                    end
                end
                DONE: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_cmd_ready <= 1'b1;
                    r_cs0_n     <= 1'b1;
                    r_drv       <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule
